// File: rtl/uart_ctrl_pkg.sv
// Shared state encoding and timing defaults for the UART transmit arbiter.
// A default watchdog limit comfortably longer than one 10-bit frame at 5208 clk/bit.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LAUNCH   = 3'd1,
    S_WAIT     = 3'd2,
    S_DONE     = 3'd3,
    S_DONE_ERR = 3'd4
  } state_t;

  localparam int CLKS_PER_BIT = 5208;
  localparam int FRAME_BITS   = 10;
  localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT;
  localparam int DEF_TIMEOUT  = 60000;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request at or after rr_ptr, cyclic order.
// Latency: combinational.
// Backpressure: none; any_vld is simply the OR of all requests.
module rr_priority_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [ID_W-1:0] win,
  output logic            any_vld
);

  logic [NREQ-1:0] rot;
  logic [ID_W-1:0] pos;

  // Modulo NREQ add; NREQ need not be a power of two.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a,
                                               input logic [ID_W-1:0] b);
    logic [ID_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (ID_W+1)'(NREQ)) s = s - (ID_W+1)'(NREQ);
    return s[ID_W-1:0];
  endfunction

  always_comb begin
    rot = '0;
    for (int i = 0; i < NREQ; i++) rot[i] = req[wrap_add(rr_ptr, ID_W'(i))];
    pos = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (rot[i]) pos = ID_W'(i);
    win     = wrap_add(rr_ptr, pos);
    any_vld = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NREQ byte requesters with round-robin fairness.
// Latency: tx_enable one cycle after req is sampled in IDLE; ack one cycle after tx_done.
// Backpressure: requests are level-held; a requester waits until granted and acked.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int N_BITS  = 8,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TO_W    = 16,
  parameter int ID_W    = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*N_BITS-1:0] data_in,
  output logic [NREQ-1:0]        ack,
  output logic                   tx_enable,
  output logic [N_BITS-1:0]      tx_data,
  input  logic                   tx_done,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id,
  output logic                   timeout_err
);

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win;
  logic            any_vld;
  logic [TO_W-1:0] count;
  logic [ID_W-1:0] next_ptr;

  rr_priority_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .win     (win),
    .any_vld (any_vld)
  );

  assign next_ptr = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      ack         <= '0;
      tx_enable   <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      count       <= '0;
    end else begin
      tx_enable   <= 1'b0;
      ack         <= '0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_vld) begin
            tx_data   <= data_in[int'(win)*N_BITS +: N_BITS];
            grant_id  <= win;
            tx_enable <= 1'b1;
            busy      <= 1'b1;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          count <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          count <= count + 1'b1;
          // done takes priority over a watchdog expiry in the same cycle
          if (tx_done) begin
            ack   <= NREQ'(1) << grant_id;
            state <= S_DONE;
          end else if (count == TO_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_DONE_ERR;
          end
        end
        S_DONE, S_DONE_ERR: begin
          rr_ptr <= next_ptr;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; tx_done is driven by hand in place of a transmitter.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int N_BITS  = 8;
  localparam int TIMEOUT = 16;
  localparam int TO_W    = 16;
  localparam int ID_W    = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*N_BITS-1:0] data_in = '0;
  logic [NREQ-1:0]        ack;
  logic                   tx_enable;
  logic [N_BITS-1:0]      tx_data;
  logic                   tx_done = 1'b0;
  logic                   busy;
  logic [ID_W-1:0]        grant_id;
  logic                   timeout_err;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(
    .NREQ    (NREQ),
    .N_BITS  (N_BITS),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W),
    .ID_W    (ID_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data_in     (data_in),
    .ack         (ack),
    .tx_enable   (tx_enable),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_byte(input int slot, input logic [7:0] v);
    data_in[slot*N_BITS +: N_BITS] = v;
  endtask

  // Bounded wait for the launch strobe; an expiry is reported as a failed check.
  task automatic wait_enable(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tx_enable && k < 50);
    check({tag, "_strobe"}, 32'(tx_enable), 32'd1);
  endtask

  initial begin
    int exp_gnt [5] = '{0, 1, 2, 3, 0};
    int k;
    logic seen_ack;

    // reset values
    tick(2);
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_enable", 32'(tx_enable), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    rst = 1'b1;

    // tx_done while IDLE with no requests is ignored
    set_byte(0, 8'h11); set_byte(1, 8'h22); set_byte(2, 8'hA5); set_byte(3, 8'h44);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    check("idle_done_busy", 32'(busy), 0);
    tick(1);
    check("idle_done_ack", 32'(ack), 0);

    // single client on slot 2
    req = 4'b0100;
    tick(1);
    check("single_enable", 32'(tx_enable), 1);
    check("single_tx_data", 32'(tx_data), 32'hA5);
    check("single_grant", 32'(grant_id), 2);
    check("single_busy", 32'(busy), 1);
    set_byte(2, 8'h3C);
    tick(1);
    check("single_enable_pulse", 32'(tx_enable), 0);
    tick(11);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    check("single_ack", 32'(ack), 32'b0100);
    check("single_no_err", 32'(timeout_err), 0);
    check("single_data_stable", 32'(tx_data), 32'hA5);
    req = 4'b0000;
    tick(1);
    check("single_ack_pulse", 32'(ack), 0);
    check("single_idle", 32'(busy), 0);

    // asynchronous reset in the middle of WAIT
    set_byte(1, 8'h5A);
    req = 4'b0010;
    wait_enable("midrst");
    check("midrst_grant", 32'(grant_id), 1);
    tick(2);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_tx_data", 32'(tx_data), 0);
    check("midrst_grant0", 32'(grant_id), 0);
    check("midrst_tx_enable", 32'(tx_enable), 0);
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    check("midrst_idle", 32'(busy), 0);

    // round robin with all four held; done 10 cycles after each strobe
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_enable($sformatf("rr%0d", f));
      check($sformatf("rr%0d_grant", f), 32'(grant_id), 32'(exp_gnt[f]));
      tick(5);
      check($sformatf("rr%0d_no_early_ack", f), 32'(ack), 0);
      tick(5);
      tx_done = 1'b1;
      tick(1);
      tx_done = 1'b0;
      check($sformatf("rr%0d_ack", f), 32'(ack), 32'(1) << exp_gnt[f]);
      if (f == 4) req = 4'b0000;
      tick(1);
      check($sformatf("rr%0d_ack_once", f), 32'(ack), 0);
    end

    // watchdog: pointer is at 1, only client 0 requests, tx_done never comes
    set_byte(0, 8'h77);
    set_byte(3, 8'h0F);
    req = 4'b0001;
    wait_enable("to");
    check("to_grant", 32'(grant_id), 0);
    check("to_tx_data", 32'(tx_data), 32'h77);
    seen_ack = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 3) req = 4'b1001;
      if (ack != '0) seen_ack = 1'b1;
    end while (!timeout_err && k < 40);
    // launch cycle, then 16 WAIT cycles, then the pulse
    check("to_delay", 32'(k), 17);
    check("to_no_ack", 32'(seen_ack), 0);
    check("to_grant_held", 32'(grant_id), 0);
    tick(1);
    check("to_pulse", 32'(timeout_err), 0);
    check("to_ack_after", 32'(ack), 0);

    // pointer advanced past client 0, so client 3 wins next
    wait_enable("race");
    check("race_grant", 32'(grant_id), 3);
    check("race_tx_data", 32'(tx_data), 32'h0F);
    tick(4);
    req = 4'b0001;
    tick(12);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    check("race_ack", 32'(ack), 32'b1000);
    check("race_no_err", 32'(timeout_err), 0);
    tick(1);
    check("race_no_err_late", 32'(timeout_err), 0);

    // client 0 retries; tx_done during LAUNCH must be ignored
    wait_enable("retry");
    check("retry_grant", 32'(grant_id), 0);
    check("retry_tx_data", 32'(tx_data), 32'h77);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    check("launch_done_busy", 32'(busy), 1);
    tick(1);
    check("launch_done_ack", 32'(ack), 0);
    tick(8);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    check("retry_ack", 32'(ack), 32'b0001);
    req = 4'b0000;
    tick(2);
    check("final_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
